// File: rtl/srconv_pkg.sv
// Shared definitions for the sample-rate converter phase control.
package srconv_pkg;

  localparam int unsigned FRAC_W_DEF = 12;
  localparam int unsigned INT_W_DEF  = 2;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONSUME = 2'd1,
    EMIT    = 2'd2
  } state_t;

endpackage

// File: rtl/phase_accumulator.sv
// Fractional phase accumulator: tracks the interpolation phase (mu) and
// how many input samples must be consumed before each output point.
module phase_accumulator
  import srconv_pkg::*;
#(
  parameter int unsigned FRAC_W = FRAC_W_DEF,
  parameter int unsigned INT_W  = INT_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [INT_W+FRAC_W-1:0] cfg_ratio,
  input  logic                    cfg_load,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [FRAC_W-1:0]       mu,
  output logic [CNT_W-1:0]        out_cnt
);

  localparam int unsigned RATIO_W = INT_W + FRAC_W;
  localparam int unsigned SUM_W   = RATIO_W + 1;
  localparam int unsigned OWE_W   = INT_W + 1;

  state_t              state;
  state_t              state_nxt;
  logic [RATIO_W-1:0]  ratio;
  logic [RATIO_W-1:0]  ratio_nxt;
  logic [FRAC_W-1:0]   frac;
  logic [FRAC_W-1:0]   frac_nxt;
  logic [OWE_W-1:0]    owe;
  logic [OWE_W-1:0]    owe_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [SUM_W-1:0]    sum;
  logic [OWE_W-1:0]    sum_int;
  logic                in_xfer;
  logic                out_xfer;

  // Handshakes are gated by en so nothing can transfer while disabled
  assign in_ready  = (state == CONSUME) && en;
  assign out_valid = (state == EMIT) && en;
  assign mu        = (state == EMIT) ? frac : '0;
  assign out_cnt   = cnt;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // Phase adder, one bit wider than the ratio so the carry is never lost
  assign sum     = SUM_W'(frac) + SUM_W'(ratio);
  assign sum_int = sum[SUM_W-1:FRAC_W];

  // State register and phase/count storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ratio <= '0;
      frac  <= '0;
      owe   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      ratio <= ratio_nxt;
      frac  <= frac_nxt;
      owe   <= owe_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_nxt = state;
    ratio_nxt = ratio;
    frac_nxt  = frac;
    owe_nxt   = owe;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (cfg_load) begin
          ratio_nxt = cfg_ratio;
        end
        // A zero ratio would never produce an input request, so hold off
        if (en && (ratio != '0)) begin
          state_nxt = CONSUME;
          frac_nxt  = '0;
          owe_nxt   = OWE_W'(1);
        end
      end
      CONSUME: begin
        if (!en) begin
          state_nxt = IDLE;
          frac_nxt  = '0;
          owe_nxt   = '0;
        end else if (in_xfer) begin
          owe_nxt = owe - OWE_W'(1);
          if (owe <= OWE_W'(1)) begin
            owe_nxt   = '0;
            state_nxt = EMIT;
          end
        end
      end
      EMIT: begin
        if (!en) begin
          state_nxt = IDLE;
          frac_nxt  = '0;
          owe_nxt   = '0;
        end else if (out_xfer) begin
          frac_nxt  = sum[FRAC_W-1:0];
          owe_nxt   = sum_int;
          cnt_nxt   = cnt + CNT_W'(1);
          // No whole input owed means another point from the same sample
          state_nxt = (sum_int == '0) ? EMIT : CONSUME;
        end
      end
      default: begin
        state_nxt = IDLE;
        frac_nxt  = '0;
        owe_nxt   = '0;
      end
    endcase
  end

endmodule
